// File: rtl/seg7_digit_driver_pkg.sv
// Shared constants for the seven-segment digit driver.
// Blank patterns, FSM state encoding and the hex glyph table.
package seg7_digit_driver_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Active-low {g,f,e,d,c,b,a} glyphs
    localparam logic [6:0] HEX_0 = 7'h40;
    localparam logic [6:0] HEX_1 = 7'h79;
    localparam logic [6:0] HEX_2 = 7'h24;
    localparam logic [6:0] HEX_3 = 7'h30;
    localparam logic [6:0] HEX_4 = 7'h19;
    localparam logic [6:0] HEX_5 = 7'h12;
    localparam logic [6:0] HEX_6 = 7'h02;
    localparam logic [6:0] HEX_7 = 7'h78;
    localparam logic [6:0] HEX_8 = 7'h00;
    localparam logic [6:0] HEX_9 = 7'h10;
    localparam logic [6:0] HEX_A = 7'h08;
    localparam logic [6:0] HEX_B = 7'h03;
    localparam logic [6:0] HEX_C = 7'h46;
    localparam logic [6:0] HEX_D = 7'h21;
    localparam logic [6:0] HEX_E = 7'h06;
    localparam logic [6:0] HEX_F = 7'h0E;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-seven-segment decoder (active-low outputs).
// Ports: nibble (4b value in), pattern (7b {g..a} out).
module seg7_hex_decode
    import seg7_digit_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        unique case (nibble)
            4'h0: pattern = HEX_0;
            4'h1: pattern = HEX_1;
            4'h2: pattern = HEX_2;
            4'h3: pattern = HEX_3;
            4'h4: pattern = HEX_4;
            4'h5: pattern = HEX_5;
            4'h6: pattern = HEX_6;
            4'h7: pattern = HEX_7;
            4'h8: pattern = HEX_8;
            4'h9: pattern = HEX_9;
            4'hA: pattern = HEX_A;
            4'hB: pattern = HEX_B;
            4'hC: pattern = HEX_C;
            4'hD: pattern = HEX_D;
            4'hE: pattern = HEX_E;
            4'hF: pattern = HEX_F;
        endcase
    end

endmodule

// File: rtl/seg7_digit_driver.sv
// 4-digit common-anode display driver: double-buffered value committed
// at frame boundaries, dead time on every digit switch, optional
// leading-zero blanking.
// Ports: clk, rst_n (sync, active low), sel (digit select), load,
// digits_in, dp_in, blank_lz in; an, seg, dp (all active low), pending out.
module seg7_digit_driver
    import seg7_digit_driver_pkg::*;
#(
    parameter int DEAD_CYCLES = 64,
    parameter int CNT_W       = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  sel,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        pending
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DEAD_CYCLES);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [1:0]        sel_q;
    logic [15:0]       active_val, shadow_val;
    logic [3:0]        active_dp, shadow_dp;
    logic              change, frame_edge;
    logic [3:0]        nibble;
    logic [6:0]        hex_seg;
    logic              lz;
    logic [3:0]        an_next;
    logic [6:0]        seg_next;
    logic              dp_next;

    assign change     = (sel != sel_q);
    assign frame_edge = (sel_q == 2'd3) && (sel == 2'd0);
    assign nibble     = active_val[{sel_q, 2'b00} +: 4];

    // Digit is a leading zero when it and every digit above it are zero
    assign lz = blank_lz && (sel_q != 2'd0)
             && ((active_val >> {sel_q, 2'b00}) == 16'h0);

    seg7_hex_decode u_dec (
        .nibble  (nibble),
        .pattern (hex_seg)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        an_next    = AN_OFF;
        seg_next   = SEG_OFF;
        dp_next    = 1'b1;
        unique case (state)
            ST_BLANK: begin
                if (change)
                    cnt_next = CNT_INIT;
                else if (cnt == '0)
                    state_next = ST_DRIVE;
                else
                    cnt_next = cnt - 1'b1;
            end
            ST_DRIVE: begin
                if (change) begin
                    state_next = ST_BLANK;
                    cnt_next   = CNT_INIT;
                end
            end
        endcase
        // Outputs follow the next state so anodes drop on the change edge
        if (state_next == ST_DRIVE) begin
            an_next  = ~(4'b0001 << sel_q);
            seg_next = lz ? SEG_OFF : hex_seg;
            dp_next  = ~active_dp[sel_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            cnt        <= CNT_INIT;
            sel_q      <= 2'd0;
            active_val <= 16'h0;
            active_dp  <= 4'h0;
            shadow_val <= 16'h0;
            shadow_dp  <= 4'h0;
            pending    <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sel_q <= sel;
            an    <= an_next;
            seg   <= seg_next;
            dp    <= dp_next;
            // Old shadow commits before a coincident load overwrites it
            if (frame_edge && pending) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
            end
            if (load) begin
                shadow_val <= digits_in;
                shadow_dp  <= dp_in;
            end
            pending <= load | (pending & ~frame_edge);
        end
    end

endmodule

// File: tb/tb_seg7_digit_driver.sv
// Directed scoreboard bench for seg7_digit_driver with DEAD_CYCLES=4.
// Walks sel through frames and checks dead time, glyphs, commit and reset.
module tb_seg7_digit_driver;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sel;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pending;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    bit   mon_on = 1'b0;

    always #5 clk = ~clk;

    seg7_digit_driver #(
        .DEAD_CYCLES (D),
        .CNT_W       (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .load      (load),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .pending   (pending)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            assert ($countones(~an) <= 1) passed++;
            else $error("FAIL an_overlap: got %b expected at most one low", an);
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpv);
        load      = 1'b1;
        digits_in = v;
        dp_in     = dpv;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Switch to digit s (optionally with a load on the same edge), measure
    // the dead time, then compare the driven digit with the queued entry.
    task automatic visit(input string tag, input logic [1:0] s,
                         input logic [6:0] eseg, input logic edp,
                         input logic ld, input logic [15:0] v);
        exp_t e;
        int   n;
        e.an  = ~(4'b0001 << s);
        e.seg = eseg;
        e.dp  = edp;
        q.push_back(e);
        sel = s;
        if (ld) begin
            load      = 1'b1;
            digits_in = v;
            dp_in     = 4'h0;
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (an != 4'hF) break;
            n++;
        end
        chk({tag, "_blank"}, 16'(n), 16'(D + 1));
        e = q.pop_front();
        chk({tag, "_an"}, {12'h0, an}, {12'h0, e.an});
        chk({tag, "_seg"}, {9'h0, seg}, {9'h0, e.seg});
        chk({tag, "_dp"}, {15'h0, dp}, {15'h0, e.dp});
        repeat (3) @(negedge clk);
    endtask

    task automatic after_reset(input string tag);
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            chk({tag, "_dead_an"}, {12'h0, an}, 16'h000F);
        end
        @(negedge clk);
        chk({tag, "_an0"}, {12'h0, an}, 16'h000E);
        chk({tag, "_seg0"}, {9'h0, seg}, 16'h0040);
        chk({tag, "_dp0"}, {15'h0, dp}, 16'h0001);
    endtask

    initial begin
        rst_n     = 1'b0;
        sel       = 2'd0;
        load      = 1'b0;
        digits_in = 16'h0;
        dp_in     = 4'h0;
        blank_lz  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_seg", {9'h0, seg}, 16'h007F);
        chk("rst_dp", {15'h0, dp}, 16'h0001);
        chk("rst_pending", {15'h0, pending}, 16'h0000);
        mon_on = 1'b1;
        rst_n  = 1'b1;
        after_reset("boot");

        do_load(16'h12AF, 4'b0100);
        chk("pend_set", {15'h0, pending}, 16'h0001);
        visit("old_d1", 2'd1, 7'h40, 1'b1, 1'b0, 16'h0);
        visit("old_d2", 2'd2, 7'h40, 1'b1, 1'b0, 16'h0);
        visit("old_d3", 2'd3, 7'h40, 1'b1, 1'b0, 16'h0);
        chk("pend_hold", {15'h0, pending}, 16'h0001);
        visit("new_d0", 2'd0, 7'h0E, 1'b1, 1'b0, 16'h0);
        chk("pend_clr", {15'h0, pending}, 16'h0000);
        visit("new_d1", 2'd1, 7'h08, 1'b1, 1'b0, 16'h0);
        visit("new_d2", 2'd2, 7'h24, 1'b0, 1'b0, 16'h0);
        visit("new_d3", 2'd3, 7'h79, 1'b1, 1'b0, 16'h0);

        blank_lz = 1'b1;
        do_load(16'h0070, 4'h0);
        visit("lz70_d0", 2'd0, 7'h40, 1'b1, 1'b0, 16'h0);
        visit("lz70_d1", 2'd1, 7'h78, 1'b1, 1'b0, 16'h0);
        visit("lz70_d2", 2'd2, 7'h7F, 1'b1, 1'b0, 16'h0);
        visit("lz70_d3", 2'd3, 7'h7F, 1'b1, 1'b0, 16'h0);
        do_load(16'h0000, 4'h0);
        visit("lz00_d0", 2'd0, 7'h40, 1'b1, 1'b0, 16'h0);
        visit("lz00_d1", 2'd1, 7'h7F, 1'b1, 1'b0, 16'h0);
        visit("lz00_d2", 2'd2, 7'h7F, 1'b1, 1'b0, 16'h0);
        visit("lz00_d3", 2'd3, 7'h7F, 1'b1, 1'b0, 16'h0);
        blank_lz = 1'b0;

        visit("z_d0", 2'd0, 7'h40, 1'b1, 1'b0, 16'h0);
        do_load(16'h1111, 4'h0);
        visit("z_d1", 2'd1, 7'h40, 1'b1, 1'b0, 16'h0);
        do_load(16'h2222, 4'h0);
        visit("z_d2", 2'd2, 7'h40, 1'b1, 1'b0, 16'h0);
        visit("z_d3", 2'd3, 7'h40, 1'b1, 1'b0, 16'h0);
        chk("pend_2222", {15'h0, pending}, 16'h0001);
        visit("two_d0", 2'd0, 7'h24, 1'b1, 1'b1, 16'h3333);
        chk("pend_edge_load", {15'h0, pending}, 16'h0001);
        visit("two_d1", 2'd1, 7'h24, 1'b1, 1'b0, 16'h0);
        visit("two_d2", 2'd2, 7'h24, 1'b1, 1'b0, 16'h0);
        visit("two_d3", 2'd3, 7'h24, 1'b1, 1'b0, 16'h0);
        visit("three_d0", 2'd0, 7'h30, 1'b1, 1'b0, 16'h0);
        chk("pend_3333", {15'h0, pending}, 16'h0000);

        do_load(16'h1234, 4'hF);
        chk("pend_pre_rst", {15'h0, pending}, 16'h0001);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_an", {12'h0, an}, 16'h000F);
        chk("mid_rst_seg", {9'h0, seg}, 16'h007F);
        chk("mid_rst_pend", {15'h0, pending}, 16'h0000);
        after_reset("mid");
        visit("post_d1", 2'd1, 7'h40, 1'b1, 1'b0, 16'h0);
        visit("post_d2", 2'd2, 7'h40, 1'b1, 1'b0, 16'h0);
        visit("post_d3", 2'd3, 7'h40, 1'b1, 1'b0, 16'h0);
        visit("post_d0", 2'd0, 7'h40, 1'b1, 1'b0, 16'h0);
        chk("post_pend", {15'h0, pending}, 16'h0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
